euler_step_scaler: RTL and testbench



---
 rtl/ode_euler_pkg.sv | 20 ++
 rtl/euler_step_scaler_fx_mul.sv | 36 +++
 rtl/euler_step_scaler.sv | 152 +++++++++++++++
 tb/tb_euler_step_scaler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ode_euler_pkg.sv
// Shared constants and FSM state encoding for the Euler step scaler.
package ode_euler_pkg;

    localparam int unsigned SIZE_DEF = 16;
    localparam int unsigned FRAC_DEF = 8;
    localparam int unsigned ST_W     = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WAIT_F = 3'd1;
    localparam state_t ST_MUL    = 3'd2;
    localparam state_t ST_ISSUE  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Signed range limits for the default data width
    localparam logic signed [SIZE_DEF-1:0] SMAX_DEF = 16'sh7FFF;
    localparam logic signed [SIZE_DEF-1:0] SMIN_DEF = 16'sh8000;

endpackage

// File: rtl/euler_step_scaler_fx_mul.sv
// Signed fixed-point multiply with floor shift and overflow detect.
// Define SCALER_SATURATE_EN to clamp overflowing results instead of wrapping.
module fx_mul
    import ode_euler_pkg::*;
#(
    parameter int unsigned W = SIZE_DEF,
    parameter int unsigned F = FRAC_DEF
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic        [W-1:0] res_c_o,
    output logic                ovf_c_o
);

    localparam int unsigned PW = 2 * W;
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic        [W:0]    upper;

    // Result fits in W bits only when the bits from the sign position up agree
    always_comb begin
        prod    = PW'(a_i) * PW'(b_i);
        shifted = prod >>> F;
        upper   = shifted[PW-1:W-1];
        ovf_c_o = ~((&upper) | ~(|upper));
`ifdef SCALER_SATURATE_EN
        res_c_o = ovf_c_o ? (shifted[PW-1] ? SMIN : SMAX) : shifted[W-1:0];
`else
        res_c_o = shifted[W-1:0];
`endif
    end

endmodule

// File: rtl/euler_step_scaler.sv
// Sequences h*f increments for a downstream accumulator, one step in flight.
// Saturating increments are selected with SCALER_SATURATE_EN (default: wrap).
module euler_step_scaler
    import ode_euler_pkg::*;
#(
    parameter int unsigned Size = SIZE_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic            clk,
    input  logic            rst_async,
    input  logic            rst_sync,
    input  logic            start,
    input  logic [Size-1:0] h,
    input  logic [15:0]     num_steps,
    input  logic            f_valid,
    input  logic [Size-1:0] f_data,
    output logic            f_ready,
    output logic [Size-1:0] inc_out,
    output logic            inc_valid,
    output logic            acc_clr,
    output logic [15:0]     step_cnt,
    output logic            busy,
    output logic            done,
    output logic            ovf
);

    localparam int unsigned CW = 16;

    state_t          state_q, state_d;
    logic [Size-1:0] h_q, h_d;
    logic [CW-1:0]   ns_q, ns_d;
    logic [Size-1:0] f_q, f_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [Size-1:0] inc_q, inc_d;
    logic            ovf_q, ovf_d;
    logic            clr_q, clr_d;
    logic            fr_q, fr_d;
    logic            iv_q, iv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [Size-1:0] mul_res;
    logic            mul_ovf;

    fx_mul #(
        .W (Size),
        .F (FRAC)
    ) u_fx_mul (
        .a_i     (h_q),
        .b_i     (f_q),
        .res_c_o (mul_res),
        .ovf_c_o (mul_ovf)
    );

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            ns_q    <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
            inc_q   <= '0;
            ovf_q   <= 1'b0;
            clr_q   <= 1'b0;
            fr_q    <= 1'b0;
            iv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            ns_q    <= ns_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
            ovf_q   <= ovf_d;
            clr_q   <= clr_d;
            fr_q    <= fr_d;
            iv_q    <= iv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; status outputs are registered from the state being entered
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        ns_d    = ns_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        inc_d   = '0;
        clr_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    h_d     = h;
                    ns_d    = num_steps;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    clr_d   = 1'b1;
                    state_d = (num_steps == '0) ? ST_DONE : ST_WAIT_F;
                end
            end
            ST_WAIT_F: begin
                if (f_valid && fr_q) begin
                    f_d     = f_data;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                inc_d   = mul_res;
                ovf_d   = ovf_q | mul_ovf;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_d == ns_q) ? ST_DONE : ST_WAIT_F;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (rst_sync) begin
            state_d = ST_IDLE;
            h_d     = '0;
            ns_d    = '0;
            f_d     = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            inc_d   = '0;
            clr_d   = 1'b0;
        end

        fr_d   = (state_d == ST_WAIT_F);
        iv_d   = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign f_ready   = fr_q;
    assign inc_out   = inc_q;
    assign inc_valid = iv_q;
    assign acc_clr   = clr_q;
    assign step_cnt  = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_euler_step_scaler.sv
// Randomized bench for euler_step_scaler with an event-scheduled reference model.
module tb_euler_step_scaler;

    logic        clk;
    logic        rst_async, rst_sync, start, f_valid;
    logic [15:0] h, num_steps, f_data;
    logic        f_ready, inc_valid, acc_clr, busy, done, ovf;
    logic [15:0] inc_out, step_cnt;

    int checks   = 0;
    int failures = 0;

    euler_step_scaler #(.Size(16), .FRAC(8)) dut (
        .clk       (clk),
        .rst_async (rst_async),
        .rst_sync  (rst_sync),
        .start     (start),
        .h         (h),
        .num_steps (num_steps),
        .f_valid   (f_valid),
        .f_data    (f_data),
        .f_ready   (f_ready),
        .inc_out   (inc_out),
        .inc_valid (inc_valid),
        .acc_clr   (acc_clr),
        .step_cnt  (step_cnt),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // h*f in Q8, floored, as plain integer arithmetic
    function automatic void ref_mul(input logic [15:0] hv, input logic [15:0] fv,
                                    output logic [15:0] res, output bit ov);
        longint p, q;
        p = longint'($signed(hv)) * longint'($signed(fv));
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        ov = (q > 32767) || (q < -32768);
`ifdef SCALER_SATURATE_EN
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
`endif
        res = 16'(q);
    endfunction

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 2))
            0:       return 16'($urandom);
            1:       return 16'($signed(12'($urandom)));
            default: return ($urandom_range(0, 1) == 1) ? 16'h7F00 : 16'h8100;
        endcase
    endfunction

    // Reference model: a run is a list of scheduled events keyed by cycle number
    int          cyc       = 0;
    bit          m_idle    = 1'b1;
    bit          m_fr      = 1'b0;
    bit          m_clr     = 1'b0;
    bit          m_ovf     = 1'b0;
    bit          m_iss_ovf = 1'b0;
    int          m_iss_at  = -10;
    int          m_done_at = -10;
    int          m_cnt     = 0;
    int          m_ns      = 0;
    logic [15:0] m_h       = '0;
    logic [15:0] m_iss_val = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
        m_clr = 1'b0;
        if (rst_async || rst_sync) begin
            m_idle = 1'b1; m_fr = 1'b0; m_ovf = 1'b0; m_cnt = 0;
            m_iss_at = -10; m_done_at = -10;
        end else if (m_idle) begin
            if (start) begin
                m_idle = 1'b0; m_h = h; m_ns = int'(num_steps); m_cnt = 0;
                m_ovf = 1'b0; m_clr = 1'b1; m_iss_at = -10; m_done_at = -10;
                if (num_steps == 16'd0) m_done_at = cyc;
                else m_fr = 1'b1;
            end
        end else if (m_fr) begin
            if (f_valid) begin
                m_fr = 1'b0;
                m_iss_at = cyc + 1;
                ref_mul(m_h, f_data, m_iss_val, m_iss_ovf);
            end
        end else if (cyc == m_iss_at) begin
            m_ovf = m_ovf | m_iss_ovf;
        end else if (cyc == m_iss_at + 1) begin
            m_cnt++;
            if (m_cnt == m_ns) m_done_at = cyc;
            else m_fr = 1'b1;
        end else if (cyc == m_done_at + 1) begin
            m_idle = 1'b1;
        end
    end

    int iv_seen   = 0;
    int done_seen = 0;

    // Compare every cycle on the falling edge
    initial forever begin
        @(negedge clk);
        if (inc_valid) iv_seen++;
        if (done) done_seen++;
        if (rst_async) begin
            chk("rst_f_ready", 32'(f_ready), 32'd0);
            chk("rst_inc_valid", 32'(inc_valid), 32'd0);
            chk("rst_inc_out", 32'(inc_out), 32'd0);
            chk("rst_acc_clr", 32'(acc_clr), 32'd0);
            chk("rst_step_cnt", 32'(step_cnt), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_ovf", 32'(ovf), 32'd0);
        end else begin
            chk("f_ready", 32'(f_ready), 32'(m_fr));
            chk("inc_valid", 32'(inc_valid), 32'(cyc == m_iss_at));
            chk("inc_out", 32'(inc_out), (cyc == m_iss_at) ? 32'(m_iss_val) : 32'd0);
            chk("acc_clr", 32'(acc_clr), 32'(m_clr));
            chk("step_cnt", 32'(step_cnt), 32'(m_cnt));
            chk("busy", 32'(busy), 32'(!m_idle));
            chk("done", 32'(done), 32'(cyc == m_done_at));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_one(input string tag, input logic [15:0] hv, input logic [15:0] fv,
                           input logic [15:0] ex, input bit eo);
        int n;
        start = 1'b1; h = hv; num_steps = 16'd1;
        tick();
        start = 1'b0;
        chk({tag, "_acc_clr"}, 32'(acc_clr), 32'd1);
        f_valid = 1'b1; f_data = fv;
        n = 0;
        while (!f_ready && n < 8) begin tick(); n++; end
        tick();
        f_valid = 1'b0;
        n = 0;
        while (!inc_valid && n < 8) begin tick(); n++; end
        chk({tag, "_latency"}, 32'(n), 32'd1);
        chk({tag, "_inc_out"}, 32'(inc_out), 32'(ex));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        tick();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] r;
        bit          o;
        int          n, base_iv, base_done;

        rst_async = 1'b1; rst_sync = 1'b0; start = 1'b0;
        h = '0; num_steps = '0; f_valid = 1'b0; f_data = '0;
        repeat (2) tick();
        rst_async = 1'b0;
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_step_cnt", 32'(step_cnt), 32'd0);

        // Hand-computed values pinning the reference arithmetic
        ref_mul(16'h0080, 16'h0200, r, o);
        chk("pin_pos", {16'(r), 15'd0, o}, {16'h0100, 16'd0});
        ref_mul(16'h0080, 16'hFF00, r, o);
        chk("pin_neg", {16'(r), 15'd0, o}, {16'hFF80, 16'd0});
        ref_mul(16'h7F00, 16'h7F00, r, o);
`ifdef SCALER_SATURATE_EN
        chk("pin_ovf", {16'(r), 15'd0, o}, {16'h7FFF, 16'd1});
`else
        chk("pin_ovf", {16'(r), 15'd0, o}, {16'h0100, 16'd1});
`endif

        run_one("basic", 16'h0080, 16'h0200, 16'h0100, 1'b0);
        run_one("negf", 16'h0080, 16'hFF00, 16'hFF80, 1'b0);
`ifdef SCALER_SATURATE_EN
        run_one("ovf", 16'h7F00, 16'h7F00, 16'h7FFF, 1'b1);
`else
        run_one("ovf", 16'h7F00, 16'h7F00, 16'h0100, 1'b1);
`endif

        // Zero steps: done straight after start
        base_iv = iv_seen;
        start = 1'b1; h = 16'h0100; num_steps = 16'd0;
        tick();
        start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_step_cnt", 32'(step_cnt), 32'd0);
        tick();
        chk("zero_idle", 32'(busy), 32'd0);
        chk("zero_no_inc", 32'(iv_seen - base_iv), 32'd0);

        // Three steps with idle gaps and a start pulse while busy
        base_iv = iv_seen;
        start = 1'b1; h = 16'h0100; num_steps = 16'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; num_steps = 16'd0;
            tick();
            start = 1'b0;
            repeat (4) tick();
            f_valid = 1'b1; f_data = 16'(16'h0040 * (k + 1));
            n = 0;
            while (!f_ready && n < 8) begin tick(); n++; end
            tick();
            f_valid = 1'b0;
        end
        n = 0;
        while (!done && n < 10) begin tick(); n++; end
        chk("three_done_seen", 32'(done), 32'd1);
        chk("three_step_cnt", 32'(step_cnt), 32'd3);
        tick();
        chk("three_pulses", 32'(iv_seen - base_iv), 32'd3);
        chk("three_idle", 32'(busy), 32'd0);

        // Async reset while a product is being formed
        start = 1'b1; h = 16'h0100; num_steps = 16'd2;
        tick();
        start = 1'b0;
        f_valid = 1'b1; f_data = 16'h0300;
        tick();
        f_valid = 1'b0;
        base_iv = iv_seen; base_done = done_seen;
        rst_async = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_f_ready", 32'(f_ready), 32'd0);
        chk("mid_rst_inc_valid", 32'(inc_valid), 32'd0);
        tick();
        rst_async = 1'b0;
        repeat (6) tick();
        chk("mid_rst_no_inc", 32'(iv_seen - base_iv), 32'd0);
        chk("mid_rst_no_done", 32'(done_seen - base_done), 32'd0);

        // Random traffic, including resets and starts while busy
        for (int i = 0; i < 3000; i++) begin
            int rr;
            rr        = int'($urandom_range(0, 99));
            rst_sync  = (rr == 0);
            rst_async = (rr == 1);
            start     = ($urandom_range(0, 3) == 0);
            h         = rand_val();
            num_steps = 16'($urandom_range(0, 4));
            f_valid   = ($urandom_range(0, 1) == 1);
            f_data    = rand_val();
            tick();
        end
        rst_async = 1'b0; rst_sync = 1'b0; start = 1'b0; f_valid = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
